// File: rtl/gumnut_ctrl_fsm.sv
// Multi-cycle control FSM for the Gumnut core: sequences fetch/decode/execute/mem/writeback,
// drives the instruction/data bus handshakes, PC/RF/ALU strobes and interrupt entry/return.
module gumnut_ctrl_fsm #(
  parameter logic INT_EN_RST = 1'b0
) (
  input  logic       clkg,
  input  logic       rst,
  input  logic [6:0] op_i,
  input  logic [2:0] func_i,
  input  logic       z_i,
  input  logic       c_i,
  input  logic       inst_ack_i,
  input  logic       data_ack_i,
  input  logic       int_req_i,
  output logic       inst_cyc_o,
  output logic       inst_stb_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       stack_push_o,
  output logic       stack_pop_o,
  output logic       alu_en_o,
  output logic       rf_we_o,
  output logic       data_cyc_o,
  output logic       data_stb_o,
  output logic       data_we_o,
  output logic       port_sel_o,
  output logic       int_ack_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_MEM        = 3'd3,
    S_WRITE_BACK = 3'd4,
    S_INT        = 3'd5,
    S_STANDBY    = 3'd6
  } state_t;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_DISP = 2'b01;
  localparam logic [1:0] PC_ADDR = 2'b10;
  localparam logic [1:0] PC_VEC  = 2'b11;

  state_t state_q, state_d;
  logic   ie_q, ie_d;

  logic cls_alu_s, cls_mem_s, cls_jump_s, cls_branch_s, cls_misc_s;

  logic       inst_stb_s, ir_we_s, pc_we_s, push_s, pop_s, alu_en_s;
  logic       rf_we_s, data_stb_s, data_we_s, port_sel_s, int_ack_s;
  logic [1:0] pc_sel_s;

  function automatic logic branch_taken(input logic [1:0] cond, input logic z, input logic c);
    logic taken;
    case (cond)
      2'b00:   taken = z;
      2'b01:   taken = ~z;
      2'b10:   taken = c;
      2'b11:   taken = ~c;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Instruction class decode; the all-ones opcode falls through every class and acts as a nop.
  always_comb begin
    cls_alu_s    = (op_i[6] == 1'b0) || (op_i[6:4] == 3'b110) || (op_i[6:3] == 4'b1110);
    cls_mem_s    = (op_i[6:5] == 2'b10);
    cls_jump_s   = (op_i[6:2] == 5'b11110);
    cls_branch_s = (op_i[6:1] == 6'b111110);
    cls_misc_s   = (op_i == 7'b1111110);
  end

  // State and interrupt-enable registers.
  always_ff @(posedge clkg or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ie_q    <= INT_EN_RST;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
    end
  end

  // Next-state and interrupt-enable update.
  always_comb begin
    state_d = state_q;
    ie_d    = ie_q;
    case (state_q)
      S_FETCH: begin
        if (inst_ack_i) state_d = S_DECODE;
        else            state_d = S_FETCH;
      end
      S_DECODE: begin
        if (int_req_i && ie_q) state_d = S_INT;
        else                   state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (cls_alu_s) begin
          state_d = S_WRITE_BACK;
        end else if (cls_mem_s) begin
          state_d = S_MEM;
        end else if (cls_misc_s) begin
          state_d = S_FETCH;
          case (func_i)
            3'b001:  ie_d = 1'b1;
            3'b010:  ie_d = 1'b1;
            3'b011:  ie_d = 1'b0;
            3'b100:  state_d = S_STANDBY;
            3'b101:  state_d = S_STANDBY;
            default: ie_d = ie_q;
          endcase
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (!data_ack_i)    state_d = S_MEM;
        else if (func_i[0]) state_d = S_FETCH;
        else                state_d = S_WRITE_BACK;
      end
      S_WRITE_BACK: state_d = S_FETCH;
      S_INT: begin
        ie_d    = 1'b0;
        state_d = S_FETCH;
      end
      S_STANDBY: begin
        if (int_req_i && ie_q) state_d = S_INT;
        else                   state_d = S_STANDBY;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode per state; ir_we is gated by rst so no IR write escapes during reset.
  always_comb begin
    inst_stb_s = 1'b0;
    ir_we_s    = 1'b0;
    pc_we_s    = 1'b0;
    pc_sel_s   = PC_INC;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    alu_en_s   = 1'b0;
    rf_we_s    = 1'b0;
    data_stb_s = 1'b0;
    data_we_s  = 1'b0;
    port_sel_s = 1'b0;
    int_ack_s  = 1'b0;
    case (state_q)
      S_FETCH: begin
        inst_stb_s = 1'b1;
        if (inst_ack_i && !rst) ir_we_s = 1'b1;
        else                    ir_we_s = 1'b0;
      end
      S_EXECUTE: begin
        if (cls_alu_s || cls_mem_s) begin
          alu_en_s = 1'b1;
        end else if (cls_branch_s) begin
          pc_we_s = 1'b1;
          if (branch_taken(func_i[1:0], z_i, c_i)) pc_sel_s = PC_DISP;
          else                                     pc_sel_s = PC_INC;
        end else if (cls_jump_s) begin
          pc_we_s  = 1'b1;
          pc_sel_s = PC_ADDR;
          push_s   = func_i[0];
        end else if (cls_misc_s) begin
          pc_we_s = 1'b1;
          case (func_i)
            3'b000, 3'b001: begin
              pop_s    = 1'b1;
              pc_sel_s = PC_VEC;
            end
            default: pc_sel_s = PC_INC;
          endcase
        end else begin
          pc_we_s = 1'b1;
        end
      end
      S_MEM: begin
        data_stb_s = 1'b1;
        data_we_s  = func_i[0];
        port_sel_s = func_i[1];
        if (data_ack_i && func_i[0]) pc_we_s = 1'b1;
        else                         pc_we_s = 1'b0;
      end
      S_WRITE_BACK: begin
        rf_we_s = 1'b1;
        pc_we_s = 1'b1;
      end
      S_INT: begin
        int_ack_s = 1'b1;
        push_s    = 1'b1;
        pc_we_s   = 1'b1;
        pc_sel_s  = PC_VEC;
      end
      default: inst_stb_s = 1'b0;
    endcase
  end

  assign inst_cyc_o   = inst_stb_s;
  assign inst_stb_o   = inst_stb_s;
  assign ir_we_o      = ir_we_s;
  assign pc_we_o      = pc_we_s;
  assign pc_sel_o     = pc_sel_s;
  assign stack_push_o = push_s;
  assign stack_pop_o  = pop_s;
  assign alu_en_o     = alu_en_s;
  assign rf_we_o      = rf_we_s;
  assign data_cyc_o   = data_stb_s;
  assign data_stb_o   = data_stb_s;
  assign data_we_o    = data_we_s;
  assign port_sel_o   = port_sel_s;
  assign int_ack_o    = int_ack_s;
  assign state_o      = state_q;

endmodule

// File: tb/tb_gumnut_ctrl_fsm.sv
// Directed bench for gumnut_ctrl_fsm: every cycle the full output vector is compared
// against a hand-written expectation.
module tb_gumnut_ctrl_fsm;

  logic       clkg = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func;
  logic       z, c, inst_ack, data_ack, int_req;
  logic       inst_cyc, inst_stb, ir_we, pc_we, push, pop, alu_en, rf_we;
  logic       data_cyc, data_stb, data_we, port_sel, int_ack;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic [17:0] obs;

  int checks = 0;
  int errors = 0;

  gumnut_ctrl_fsm #(.INT_EN_RST(1'b0)) dut (
    .clkg(clkg), .rst(rst), .op_i(op), .func_i(func), .z_i(z), .c_i(c),
    .inst_ack_i(inst_ack), .data_ack_i(data_ack), .int_req_i(int_req),
    .inst_cyc_o(inst_cyc), .inst_stb_o(inst_stb), .ir_we_o(ir_we), .pc_we_o(pc_we),
    .pc_sel_o(pc_sel), .stack_push_o(push), .stack_pop_o(pop), .alu_en_o(alu_en),
    .rf_we_o(rf_we), .data_cyc_o(data_cyc), .data_stb_o(data_stb), .data_we_o(data_we),
    .port_sel_o(port_sel), .int_ack_o(int_ack), .state_o(state)
  );

  always #5 clkg = ~clkg;

  assign obs = {state, inst_cyc, inst_stb, ir_we, pc_we, pc_sel, push, pop, alu_en, rf_we,
                data_cyc, data_stb, data_we, port_sel, int_ack};

  function automatic logic [17:0] mk(input logic [2:0] st, input logic ist, input logic irw,
                                     input logic pcw, input logic [1:0] sel, input logic psh,
                                     input logic pp, input logic alu, input logic rfw,
                                     input logic dst, input logic dwe, input logic psl,
                                     input logic iak);
    return {st, ist, ist, irw, pcw, sel, psh, pp, alu, rfw, dst, dst, dwe, psl, iak};
  endfunction

  task automatic nx();
    @(negedge clkg);
  endtask

  task automatic ck(input string tag, input logic [17:0] exp);
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [17:0] fw, fa, dec, exa, wb, mem_ld, sby;

  initial begin
    fw     = mk(3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fa     = mk(3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dec    = mk(3'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exa    = mk(3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wb     = mk(3'd4, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ld = mk(3'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sby    = mk(3'd6, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; op = 7'd0; func = 3'd0; z = 1'b0; c = 1'b0;
    inst_ack = 1'b0; data_ack = 1'b0; int_req = 1'b0;

    // reset state and fetch stall
    nx(); ck("reset", fw);
    nx(); rst = 1'b0; ck("fetch_stall", fw);

    // 1: arith-imm, 4 cycles
    nx(); inst_ack = 1'b1; op = 7'b0000000; func = 3'b000; ck("t1_fetch", fa);
    nx(); ck("t1_decode", dec);
    nx(); ck("t1_exec", exa);
    nx(); ck("t1_wb", wb);

    // 2: ldm with data_ack delayed 3 cycles
    nx(); op = 7'b1000000; func = 3'b000; ck("t2_fetch", fa);
    nx(); ck("t2_decode", dec);
    nx(); ck("t2_exec", exa);
    for (int i = 0; i < 3; i++) begin
      nx(); ck("t2_mem_wait", mem_ld);
    end
    nx(); data_ack = 1'b1; ck("t2_mem_ack", mem_ld);
    nx(); data_ack = 1'b0; ck("t2_wb", wb);

    // out (port store): immediate ack, pc advances from MEM
    nx(); op = 7'b1011000; func = 3'b011; ck("out_fetch", fa);
    nx(); ck("out_decode", dec);
    nx(); ck("out_exec", exa);
    nx(); data_ack = 1'b1;
    ck("out_mem_ack", mk(3'd3, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));

    // 3: branches
    nx(); data_ack = 1'b0; op = 7'b1111100; func = 3'b000; z = 1'b1; ck("bz1_fetch", fa);
    nx(); ck("bz1_decode", dec);
    nx(); ck("bz1_exec", mk(3'd2, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    nx(); z = 1'b0; ck("bz0_fetch", fa);
    nx(); ck("bz0_decode", dec);
    nx(); ck("bz0_exec", mk(3'd2, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    nx(); func = 3'b011; c = 1'b0; ck("bnc_fetch", fa);
    nx(); ck("bnc_decode", dec);
    nx(); ck("bnc_exec", mk(3'd2, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // 4: jsb then ret
    nx(); op = 7'b1111001; func = 3'b001; ck("jsb_fetch", fa);
    nx(); ck("jsb_decode", dec);
    nx(); ck("jsb_exec", mk(3'd2, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    nx(); op = 7'b1111110; func = 3'b000; ck("ret_fetch", fa);
    nx(); ck("ret_decode", dec);
    nx(); ck("ret_exec", mk(3'd2, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // 5: enai, then held int_req taken once
    nx(); func = 3'b010; ck("enai_fetch", fa);
    nx(); ck("enai_decode", dec);
    nx(); ck("enai_exec", mk(3'd2, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    nx(); op = 7'b0000000; func = 3'b000; int_req = 1'b1; ck("int_fetch", fa);
    nx(); ck("int_decode", dec);
    nx(); ck("int_entry", mk(3'd5, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    nx(); ck("refetch", fa);
    nx(); ck("refetch_decode", dec);
    nx(); ck("req_not_retaken", exa);
    nx(); int_req = 1'b0; ck("refetch_wb", wb);

    // 6: enai, stby, wake by interrupt pulse
    nx(); op = 7'b1111110; func = 3'b010; ck("enai2_fetch", fa);
    nx(); ck("enai2_decode", dec);
    nx(); ck("enai2_exec", mk(3'd2, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    nx(); func = 3'b101; ck("stby_fetch", fa);
    nx(); ck("stby_decode", dec);
    nx(); ck("stby_exec", mk(3'd2, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    nx(); ck("standby_a", sby);
    nx(); ck("standby_b", sby);
    nx(); int_req = 1'b1; ck("standby_req", sby);
    nx(); int_req = 1'b0;
    ck("wake_int", mk(3'd5, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

    // rst in the middle of a data cycle
    nx(); op = 7'b1000000; func = 3'b000; ck("rm_fetch", fa);
    nx(); ck("rm_decode", dec);
    nx(); ck("rm_exec", exa);
    nx(); ck("rm_mem", mem_ld);
    #2; rst = 1'b1; ck("rst_mid_mem", fw);
    nx(); ck("rst_held", fw);

    // ie back to 0 after reset: stby is a permanent halt
    nx(); rst = 1'b0; op = 7'b1111110; func = 3'b101; int_req = 1'b1; ck("halt_fetch", fa);
    nx(); ck("halt_decode", dec);
    nx(); ck("halt_exec", mk(3'd2, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    nx(); ck("halt_a", sby);
    nx(); ck("halt_b", sby);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
